issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Issue controller between instr_decode and execute in the arriskv core.
- Holds each decoded op at the decode/execute boundary until it is hazard-free, then issues it via a valid/ready handshake.
- Keeps a per-register scoreboard of pending writes from multi-cycle units, fed by writeback completions.
- Sequences fences (drains in-flight ops) and drops the held op on flush.

Parameters:
n_regs_p, 32, number of architectural registers (x0 hardwired zero)
wd_addr_p, 5, register address width, equals clog2(n_regs_p)
max_inflight_p, 4, max outstanding multi-cycle ops (>=1)
wd_cnt_p, 32, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_dec_valid  in  1  decode presents an op
o_dec_ready  out  1  op consumed (issued or dropped)
i_rs1_addr  in  wd_addr_p  source 1 address
i_rs1_used  in  1  op reads rs1
i_rs2_addr  in  wd_addr_p  source 2 address
i_rs2_used  in  1  op reads rs2
i_rd_addr  in  wd_addr_p  destination address
i_rd_wen  in  1  op writes rd
i_multicycle  in  1  result returns later via writeback port
i_fence  in  1  op is a fence
o_exe_valid  out  1  issue to execute
i_exe_ready  in  1  execute accepts
i_wb_valid  in  1  multi-cycle result written back
i_wb_addr  in  wd_addr_p  register written back
i_flush  in  1  drop held op (branch/jump redirect)
o_busy_regs  out  n_regs_p  scoreboard, bit i = write pending to xi
o_inflight  out  clog2(max_inflight_p+1)  outstanding multi-cycle ops
o_state  out  2  FSM state: 0 RUN, 1 STALL, 2 DRAIN
o_stall_cycles  out  wd_cnt_p  saturating stall counter
o_wb_err  out  1  one-cycle pulse: writeback to non-busy register

Behaviour:
- Reset (async assert, sync deassert at next clk edge): busy=0, inflight=0, state=RUN, stall_cycles=0, wb_err=0. Outputs o_exe_valid and o_dec_ready are combinational from inputs and registered state. During reset they are 0, because the held op is treated as dropped.
- Hazard is combinational against the *registered* busy vector. There is no same-cycle writeback bypass, so a reg cleared this cycle is usable next cycle. The hazard is the OR of:
  - rs1_used & rs1!=0 & busy[rs1]
  - rs2_used & rs2!=0 & busy[rs2]
  - rd_wen & rd!=0 & busy[rd] (WAW)
  - multicycle & rd_wen & inflight==max_inflight_p
  - fence & inflight!=0
- o_exe_valid = i_dec_valid & !hazard & !i_flush.
- o_dec_ready = (i_exe_ready & !hazard) | i_flush.
- Issue fires when o_exe_valid & i_exe_ready. Single-cycle ops need no scoreboard action.
- On fire with multicycle & rd_wen & rd!=0: set busy[rd] and increment inflight. Multicycle with rd=x0 or !rd_wen: inflight not incremented.
- Writeback: if i_wb_valid & busy[wb_addr], clear the bit and decrement inflight. If the bit is not busy (including x0), state is unchanged and o_wb_err pulses the next cycle.
- Simultaneous issue-set and wb-clear on different regs: both apply; inflight net change 0. Same reg is impossible because WAW blocks the set.
- i_flush does not alter busy/inflight; in-flight ops still complete.
- FSM (registered):
  - RUN->STALL: i_dec_valid & hazard & !fence-hazard & !flush
  - RUN->DRAIN: i_dec_valid & fence & inflight!=0 & !flush
  - STALL->RUN: no hazard, or !i_dec_valid
  - DRAIN->RUN: inflight==0 (registered)
  - Any state->RUN on i_flush. The FSM is observational only and does not gate issue.
- stall_cycles increments each cycle with i_dec_valid & hazard & !i_flush, and saturates at all-ones.
- i_exe_ready low with no hazard is backpressure, not a stall: no counter increment, state stays RUN.

Test Plan:
- Issue multicycle op rd=x5, then dependent op rs1=x5 -> o_exe_valid=0 and state=STALL until wb x5. Dependent op issues the cycle after wb; stall_cycles equals the wait length.
- Issue 4 multicycle ops rd=x1..x4, then 5th rd=x6 -> blocked, inflight=4. wb x2 -> 5th issues next cycle, inflight stays 4.
- Multicycle rd=x7 pending, fence presented -> state=DRAIN, no issue. wb x7 -> inflight=0, fence issues, state=RUN.
- Dependent op stalled on x5, assert i_flush -> o_dec_ready=1, o_exe_valid=0, state=RUN, busy[5] still 1.
- wb x9 while not busy -> o_wb_err pulses 1 cycle, inflight unchanged. rs1=x0 with multicycle rd=x0 -> no hazard, busy[0] stays 0.
- Assert rst mid-operation with busy={x3,x8} -> immediately busy=0, inflight=0, state=RUN, counter=0.

Source files
------------

// File: rtl/issue_ctrl.sv
// issue_ctrl: issue stage between instr_decode and execute.
//
// Holds the decoded op at the decode/execute boundary until it is
// hazard-free, then issues it to execute with a valid/ready handshake.
// A per-register scoreboard tracks pending writes from multi-cycle units.
// Writeback completions clear it. Fences wait until every in-flight op
// has drained. A flush drops the held op.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   i_dec_valid         decode presents an op
//   o_dec_ready         op consumed (issued or dropped by flush)
//   i_rs1_*/i_rs2_*     source operand addresses and use flags
//   i_rd_addr/i_rd_wen  destination register and write enable
//   i_multicycle        result returns later through the writeback port
//   i_fence             op is a fence
//   o_exe_valid         issue to execute
//   i_exe_ready         execute accepts
//   i_wb_valid/addr     multi-cycle writeback completion
//   i_flush             drop the held op (redirect)
//   o_busy_regs         scoreboard; bit i = write pending to xi
//   o_inflight          number of outstanding multi-cycle ops
//   o_state             0 RUN, 1 STALL, 2 DRAIN (observational only)
//   o_stall_cycles      saturating count of hazard-stalled cycles
//   o_wb_err            one-cycle pulse after a writeback to a non-busy reg
module issue_ctrl #(
  parameter int n_regs_p       = 32,
  parameter int wd_addr_p      = 5,
  parameter int max_inflight_p = 4,
  parameter int wd_cnt_p       = 32,
  localparam int wd_inf_p      = $clog2(max_inflight_p + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_dec_valid,
  output logic                  o_dec_ready,
  input  logic [wd_addr_p-1:0]  i_rs1_addr,
  input  logic                  i_rs1_used,
  input  logic [wd_addr_p-1:0]  i_rs2_addr,
  input  logic                  i_rs2_used,
  input  logic [wd_addr_p-1:0]  i_rd_addr,
  input  logic                  i_rd_wen,
  input  logic                  i_multicycle,
  input  logic                  i_fence,
  output logic                  o_exe_valid,
  input  logic                  i_exe_ready,
  input  logic                  i_wb_valid,
  input  logic [wd_addr_p-1:0]  i_wb_addr,
  input  logic                  i_flush,
  output logic [n_regs_p-1:0]   o_busy_regs,
  output logic [wd_inf_p-1:0]   o_inflight,
  output logic [1:0]            o_state,
  output logic [wd_cnt_p-1:0]   o_stall_cycles,
  output logic                  o_wb_err
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [wd_inf_p-1:0] max_inf = wd_inf_p'(max_inflight_p);

  state_t                state_q, state_d;
  logic [n_regs_p-1:0]   busy_q, busy_d, set_vec, clr_vec;
  logic [wd_inf_p-1:0]   inflight_q, inflight_d;
  logic [wd_cnt_p-1:0]   stall_q;
  logic                  wb_err_q;

  logic raw1, raw2, waw, full_haz, fence_haz, hazard;
  logic fire, set_en, clr_en, stall_en;

  // Hazards look only at the registered scoreboard: a register cleared by
  // writeback this cycle becomes usable on the next one.
  always_comb begin
    raw1      = i_rs1_used && (i_rs1_addr != '0) && busy_q[i_rs1_addr];
    raw2      = i_rs2_used && (i_rs2_addr != '0) && busy_q[i_rs2_addr];
    waw       = i_rd_wen   && (i_rd_addr  != '0) && busy_q[i_rd_addr];
    full_haz  = i_multicycle && i_rd_wen && (inflight_q == max_inf);
    fence_haz = i_fence && (inflight_q != '0);
    hazard    = raw1 || raw2 || waw || full_haz || fence_haz;
  end

  // x0 is never marked busy, so an op writing x0 issues without a slot.
  // A multi-cycle write to x0 also takes no slot. Its writeback, if any,
  // therefore reports an error.
  always_comb begin
    fire     = o_exe_valid && i_exe_ready;
    set_en   = fire && i_multicycle && i_rd_wen && (i_rd_addr != '0);
    clr_en   = i_wb_valid && busy_q[i_wb_addr];
    stall_en = i_dec_valid && hazard && !i_flush;
    set_vec  = set_en ? (n_regs_p'(1) << i_rd_addr) : '0;
    clr_vec  = clr_en ? (n_regs_p'(1) << i_wb_addr) : '0;
    // WAW blocks a set on a busy reg, so set and clear never hit one bit.
    busy_d   = (busy_q | set_vec) & ~clr_vec;
    case ({set_en, clr_en})
      2'b10:   inflight_d = inflight_q + wd_inf_p'(1);
      2'b01:   inflight_d = inflight_q - wd_inf_p'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wb_err_q   <= i_wb_valid && !busy_q[i_wb_addr];
      if (stall_en && (stall_q != '1))
        stall_q <= stall_q + wd_cnt_p'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM: next state. DRAIN has priority over STALL when the op is a fence
  // with ops still outstanding.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (i_dec_valid && fence_haz)   state_d = DRAIN;
          else if (i_dec_valid && hazard) state_d = STALL;
        end
        STALL:   if (!hazard || !i_dec_valid) state_d = RUN;
        DRAIN:   if (inflight_q == '0)        state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // FSM: outputs. During reset the held op is treated as dropped, so
  // both handshake outputs stay low.
  always_comb begin
    o_exe_valid    = !rst && i_dec_valid && !hazard && !i_flush;
    o_dec_ready    = !rst && ((i_exe_ready && !hazard) || i_flush);
    o_state        = state_q;
    o_busy_regs    = busy_q;
    o_inflight     = inflight_q;
    o_stall_cycles = stall_q;
    o_wb_err       = wb_err_q;
  end

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
  localparam int NREG = 32;
  localparam int MAXI = 4;
  localparam int WCNT = 4;  // narrow counter so saturation is reachable
  localparam int SAT  = (1 << WCNT) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic i_dec_valid, i_rs1_used, i_rs2_used, i_rd_wen, i_multicycle, i_fence;
  logic [4:0] i_rs1_addr, i_rs2_addr, i_rd_addr, i_wb_addr;
  logic i_exe_ready, i_wb_valid, i_flush;
  logic o_dec_ready, o_exe_valid, o_wb_err;
  logic [NREG-1:0] o_busy_regs;
  logic [2:0] o_inflight;
  logic [1:0] o_state;
  logic [WCNT-1:0] o_stall_cycles;

  int n_chk = 0, n_fail = 0;

  issue_ctrl #(.n_regs_p(NREG), .wd_addr_p(5), .max_inflight_p(MAXI), .wd_cnt_p(WCNT)) dut (
    .clk(clk), .rst(rst), .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs1_used(i_rs1_used), .i_rs2_addr(i_rs2_addr),
    .i_rs2_used(i_rs2_used), .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
    .i_multicycle(i_multicycle), .i_fence(i_fence), .o_exe_valid(o_exe_valid),
    .i_exe_ready(i_exe_ready), .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr),
    .i_flush(i_flush), .o_busy_regs(o_busy_regs), .o_inflight(o_inflight),
    .o_state(o_state), .o_stall_cycles(o_stall_cycles), .o_wb_err(o_wb_err));

  always #5 clk = ~clk;

  // Reference model: the set of pending destinations is a plain queue.
  // Busy = membership, inflight = queue length.
  int pend[$];
  int m_state;  // 0 RUN, 1 STALL, 2 DRAIN
  int m_stall;
  bit m_err;

  function automatic bit m_busy(input int r);
    foreach (pend[k]) if (pend[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] m_busy_vec();
    logic [NREG-1:0] v = '0;
    foreach (pend[k]) v[pend[k]] = 1'b1;
    return v;
  endfunction

  function automatic bit m_haz();
    bit h = 1'b0;
    if (i_rs1_used && i_rs1_addr != 0 && m_busy(int'(i_rs1_addr))) h = 1'b1;
    if (i_rs2_used && i_rs2_addr != 0 && m_busy(int'(i_rs2_addr))) h = 1'b1;
    if (i_rd_wen && i_rd_addr != 0 && m_busy(int'(i_rd_addr))) h = 1'b1;
    if (i_multicycle && i_rd_wen && pend.size() == MAXI) h = 1'b1;
    if (i_fence && pend.size() != 0) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_valid();
    return i_dec_valid && !m_haz() && !i_flush;
  endfunction

  function automatic bit m_ready();
    return (i_exe_ready && !m_haz()) || i_flush;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  function automatic void m_edge();
    bit h = m_haz();
    bit fh = i_fence && pend.size() != 0;
    bit fire = m_valid() && i_exe_ready;
    int nst = m_state;
    if (i_flush) nst = 0;
    else if (m_state == 0) begin
      if (i_dec_valid && fh) nst = 2;
      else if (i_dec_valid && h) nst = 1;
    end else if (m_state == 1) begin
      if (!h || !i_dec_valid) nst = 0;
    end else if (pend.size() == 0) nst = 0;
    if (i_dec_valid && h && !i_flush && m_stall < SAT) m_stall++;
    m_err = i_wb_valid && !m_busy(int'(i_wb_addr));
    if (i_wb_valid)
      foreach (pend[k]) if (pend[k] == int'(i_wb_addr)) begin pend.delete(k); break; end
    if (fire && i_multicycle && i_rd_wen && i_rd_addr != 0) pend.push_back(int'(i_rd_addr));
    m_state = nst;
  endfunction

  task automatic m_clear();
    pend.delete(); m_state = 0; m_stall = 0; m_err = 1'b0;
  endtask

  task automatic idle();
    i_dec_valid = 0; i_rs1_used = 0; i_rs2_used = 0; i_rd_wen = 0; i_multicycle = 0;
    i_fence = 0; i_rs1_addr = 0; i_rs2_addr = 0; i_rd_addr = 0; i_wb_addr = 0;
    i_exe_ready = 1; i_wb_valid = 0; i_flush = 0;
  endtask

  task automatic op(input int rs1, input bit u1, input int rs2, input bit u2,
                    input int rd, input bit wen, input bit mc, input bit fen);
    i_dec_valid = 1; i_rs1_addr = 5'(rs1); i_rs1_used = u1; i_rs2_addr = 5'(rs2);
    i_rs2_used = u2; i_rd_addr = 5'(rd); i_rd_wen = wen; i_multicycle = mc; i_fence = fen;
  endtask

  task automatic wb(input bit v, input int r);
    i_wb_valid = v; i_wb_addr = 5'(r);
  endtask

  // Model edge, then the DUT edge; return 1 time unit after it.
  task automatic adv();
    m_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    @(posedge clk); #1;
    rst = 0; m_clear();
  endtask

  task automatic test_reset();
    idle(); i_dec_valid = 1; i_flush = 1;
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_exe_valid got %0b want 0", o_exe_valid); end
    n_chk++; if (o_dec_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dec_ready got %0b want 0", o_dec_ready); end
    n_chk++; if (o_busy_regs !== '0) begin n_fail++; $display("FAIL reset_busy got %h want 0", o_busy_regs); end
    n_chk++; if (o_inflight !== 3'd0) begin n_fail++; $display("FAIL reset_inflight got %0d want 0", o_inflight); end
    n_chk++; if (o_state !== 2'd0 || o_stall_cycles !== '0 || o_wb_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_regs got st=%0d cnt=%0d err=%0b want 0/0/0", o_state, o_stall_cycles, o_wb_err); end
    do_reset();
  endtask

  task automatic test_raw_stall();
    do_reset();
    op(0, 0, 0, 0, 5, 1, 1, 0);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue got %0b want 1", o_exe_valid); end
    adv();
    op(5, 1, 0, 0, 10, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) wb(1, 5);
      @(negedge clk);
      n_chk++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL raw_blocked c=%0d got %0b want 0", c, o_exe_valid); end
      n_chk++; if (o_state !== 2'(m_state)) begin n_fail++; $display("FAIL raw_state c=%0d got %0d want %0d", c, o_state, m_state); end
      adv();
    end
    wb(0, 0);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL raw_after_wb got %0b want 1", o_exe_valid); end
    n_chk++; if (o_stall_cycles !== 4'd4) begin n_fail++; $display("FAIL raw_stall_cnt got %0d want 4", o_stall_cycles); end
    n_chk++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL raw_state_wb got %0d want 1", o_state); end
    adv(); idle();
    @(negedge clk);
    n_chk++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL raw_state_end got %0d want 0", o_state); end
  endtask

  task automatic test_stall_sat();
    do_reset();
    op(0, 0, 0, 0, 5, 1, 1, 0); adv();
    op(0, 0, 5, 1, 6, 1, 0, 0);
    for (int c = 0; c < 20; c++) adv();
    @(negedge clk);
    n_chk++; if (o_stall_cycles !== 4'(SAT)) begin n_fail++; $display("FAIL stall_saturate got %0d want %0d", o_stall_cycles, SAT); end
    n_chk++; if (int'(o_stall_cycles) !== m_stall) begin n_fail++; $display("FAIL stall_model got %0d want %0d", o_stall_cycles, m_stall); end
  endtask

  task automatic test_inflight_limit();
    do_reset();
    for (int r = 1; r <= 4; r++) begin op(0, 0, 0, 0, r, 1, 1, 0); adv(); end
    op(0, 0, 0, 0, 6, 1, 1, 0);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL full_blocked got %0b want 0", o_exe_valid); end
    n_chk++; if (o_inflight !== 3'd4) begin n_fail++; $display("FAIL full_inflight got %0d want 4", o_inflight); end
    n_chk++; if (o_busy_regs !== 32'h1E) begin n_fail++; $display("FAIL full_busy got %h want 1e", o_busy_regs); end
    adv();
    wb(1, 2);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL full_wb_cycle got %0b want 0", o_exe_valid); end
    adv(); wb(0, 0);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL full_issue5 got %0b want 1", o_exe_valid); end
    adv(); idle();
    @(negedge clk);
    n_chk++; if (o_inflight !== 3'd4) begin n_fail++; $display("FAIL full_inflight_end got %0d want 4", o_inflight); end
    n_chk++; if (o_busy_regs !== 32'h5A) begin n_fail++; $display("FAIL full_busy_end got %h want 5a", o_busy_regs); end
  endtask

  task automatic test_fence_drain();
    do_reset();
    op(0, 0, 0, 0, 7, 1, 1, 0); adv();
    op(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b0) begin n_fail++; $display("FAIL fence_blocked got %0b want 0", o_exe_valid); end
    adv();
    @(negedge clk);
    n_chk++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL fence_drain got %0d want 2", o_state); end
    wb(1, 7); adv(); wb(0, 0);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b1 || o_inflight !== 3'd0) begin
      n_fail++; $display("FAIL fence_issue got v=%0b inf=%0d want 1/0", o_exe_valid, o_inflight); end
    adv(); idle();
    @(negedge clk);
    n_chk++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL fence_run got %0d want 0", o_state); end
  endtask

  task automatic test_flush();
    do_reset();
    op(0, 0, 0, 0, 5, 1, 1, 0); adv();
    op(5, 1, 0, 0, 9, 1, 0, 0); adv(); adv();
    i_flush = 1;
    @(negedge clk);
    n_chk++; if (o_dec_ready !== 1'b1 || o_exe_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_hs got rdy=%0b v=%0b want 1/0", o_dec_ready, o_exe_valid); end
    adv(); idle();
    @(negedge clk);
    n_chk++; if (o_state !== 2'd0 || o_busy_regs[5] !== 1'b1) begin
      n_fail++; $display("FAIL flush_after got st=%0d b5=%0b want 0/1", o_state, o_busy_regs[5]); end
  endtask

  task automatic test_wb_err_x0();
    do_reset();
    wb(1, 9); adv(); wb(0, 0);
    @(negedge clk);
    n_chk++; if (o_wb_err !== 1'b1 || o_inflight !== 3'd0) begin
      n_fail++; $display("FAIL wberr_pulse got err=%0b inf=%0d want 1/0", o_wb_err, o_inflight); end
    adv();
    @(negedge clk);
    n_chk++; if (o_wb_err !== 1'b0) begin n_fail++; $display("FAIL wberr_clear got %0b want 0", o_wb_err); end
    op(0, 1, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    n_chk++; if (o_exe_valid !== 1'b1) begin n_fail++; $display("FAIL x0_issue got %0b want 1", o_exe_valid); end
    adv(); idle();
    @(negedge clk);
    n_chk++; if (o_busy_regs[0] !== 1'b0 || o_inflight !== 3'd0) begin
      n_fail++; $display("FAIL x0_nobusy got b0=%0b inf=%0d want 0/0", o_busy_regs[0], o_inflight); end
  endtask

  task automatic test_backpressure();
    do_reset();
    op(1, 1, 2, 1, 3, 1, 0, 0); i_exe_ready = 0;
    adv(); adv();
    @(negedge clk);
    n_chk++; if (o_dec_ready !== 1'b0 || o_exe_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hs got rdy=%0b v=%0b want 0/1", o_dec_ready, o_exe_valid); end
    n_chk++; if (o_stall_cycles !== '0 || o_state !== 2'd0) begin
      n_fail++; $display("FAIL bp_nostall got cnt=%0d st=%0d want 0/0", o_stall_cycles, o_state); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    op(0, 0, 0, 0, 3, 1, 1, 0); adv();
    op(0, 0, 0, 0, 8, 1, 1, 0); adv();
    op(3, 1, 0, 0, 4, 1, 0, 0); adv();
    @(negedge clk);
    n_chk++; if (o_busy_regs !== 32'h108) begin n_fail++; $display("FAIL areset_pre got %h want 108", o_busy_regs); end
    #2 rst = 1; #1;
    n_chk++; if (o_busy_regs !== '0 || o_inflight !== 3'd0 || o_state !== 2'd0 || o_stall_cycles !== '0) begin
      n_fail++; $display("FAIL areset_now got b=%h inf=%0d st=%0d cnt=%0d want 0", o_busy_regs, o_inflight, o_state, o_stall_cycles); end
    m_clear(); idle();
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      op(int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
         int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
         1'($urandom_range(0, 9) == 0));
      i_dec_valid = 1'($urandom_range(0, 4) != 0);
      i_exe_ready = 1'($urandom_range(0, 3) != 0);
      i_flush     = 1'($urandom_range(0, 19) == 0);
      if (pend.size() != 0 && $urandom_range(0, 9) < 4) wb(1, pend[$urandom_range(0, pend.size() - 1)]);
      else wb(1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)));
      @(negedge clk);
      n_chk++;
      if (o_exe_valid !== m_valid() || o_dec_ready !== m_ready() || o_busy_regs !== m_busy_vec() ||
          int'(o_inflight) !== pend.size() || int'(o_state) !== m_state ||
          int'(o_stall_cycles) !== m_stall || o_wb_err !== m_err) begin
        n_fail++;
        $display("FAIL rand c=%0d got v=%0b r=%0b b=%h inf=%0d st=%0d cnt=%0d err=%0b want v=%0b r=%0b b=%h inf=%0d st=%0d cnt=%0d err=%0b",
                 c, o_exe_valid, o_dec_ready, o_busy_regs, o_inflight, o_state, o_stall_cycles, o_wb_err,
                 m_valid(), m_ready(), m_busy_vec(), pend.size(), m_state, m_stall, m_err);
      end
      adv();
      if ($urandom_range(0, 99) == 0) m_stall = m_stall;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_stall();
    test_stall_sat();
    test_inflight_limit();
    test_fence_drain();
    test_flush();
    test_wb_err_x0();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
